// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz VGA timing constants and helpers for vga_timing_gen.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_TOTAL  = 800;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_TOTAL  = 525;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_ACTIVE = 480;

  localparam int unsigned H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + DEF_H_ACTIVE - 1;
  localparam int unsigned V_ACT_START = DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + DEF_V_ACTIVE - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Inclusive window test on a raster coordinate.
  function automatic logic in_window(cnt_t val, int unsigned lo, int unsigned hi);
    return (val >= CNT_W'(lo)) && (val <= CNT_W'(hi));
  endfunction

endpackage

// File: rtl/pixel_en_gen.sv
// Divides the system clock into a registered one-clk pixel enable every CLK_DIV clocks.
module pixel_en_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pixel_en
);

  logic r_pixel_en;

  generate
    if (CLK_DIV <= 1) begin : g_nodiv
      always_ff @(posedge clk) begin
        if (rst) r_pixel_en <= 1'b0;
        else     r_pixel_en <= 1'b1;
      end
    end else begin : g_div
      localparam int unsigned DivW = $clog2(CLK_DIV);
      logic [DivW-1:0] r_div;
      logic            w_wrap;

      assign w_wrap = (r_div >= DivW'(CLK_DIV - 1));

      // Pulse lands on the same edge the divider wraps, i.e. clk CLK_DIV after release.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_div      <= '0;
          r_pixel_en <= 1'b0;
        end else begin
          r_div      <= w_wrap ? '0 : r_div + DivW'(1);
          r_pixel_en <= w_wrap;
        end
      end
    end
  endgenerate

  assign pixel_en = r_pixel_en;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, syncs, active flag, pixel enable and frame tick.
// Define VGA_FRAME_COUNT_EN to build the 16-bit frame counter; otherwise frame_count is 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             hSync,
  output logic             vSync,
  output logic             pixel_en,
  output logic             frame_tick,
  output logic [15:0]      frame_count
);

  localparam int unsigned HActStart = H_SYNC + H_BP;
  localparam int unsigned HActEnd   = HActStart + H_ACTIVE - 1;
  localparam int unsigned VActStart = V_SYNC + V_BP;
  localparam int unsigned VActEnd   = VActStart + V_ACTIVE - 1;

  logic w_pixel_en;
  cnt_t r_h, r_v;
  cnt_t w_h_next, w_v_next;
  logic w_h_last, w_v_last, w_frame_wrap;
  logic r_bright, r_hsync, r_vsync, r_frame_tick;

  pixel_en_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_en_gen (
    .clk     (clk),
    .rst     (rst),
    .pixel_en(w_pixel_en)
  );

  // ">=" so out-of-range states recover on the next pixel enable.
  assign w_h_last = (r_h >= CNT_W'(H_TOTAL - 1));
  assign w_v_last = (r_v >= CNT_W'(V_TOTAL - 1));

  always_comb begin
    w_h_next     = r_h;
    w_v_next     = r_v;
    w_frame_wrap = 1'b0;
    if (w_pixel_en) begin
      if (w_h_last) begin
        w_h_next = '0;
        if (w_v_last) begin
          w_v_next     = '0;
          w_frame_wrap = 1'b1;
        end else begin
          w_v_next = r_v + CNT_W'(1);
        end
      end else begin
        w_h_next = r_h + CNT_W'(1);
        if (r_v > CNT_W'(V_TOTAL - 1)) w_v_next = '0;
      end
    end
  end

  // Decoded outputs use next counter values so they line up with hCount/vCount.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h          <= '0;
      r_v          <= '0;
      r_bright     <= 1'b0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_h          <= w_h_next;
      r_v          <= w_v_next;
      r_bright     <= in_window(w_h_next, HActStart, HActEnd) &&
                      in_window(w_v_next, VActStart, VActEnd);
      r_hsync      <= (w_h_next >= CNT_W'(H_SYNC));
      r_vsync      <= (w_v_next >= CNT_W'(V_SYNC));
      r_frame_tick <= w_frame_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clk) begin
    if (rst)               r_frame_count <= '0;
    else if (w_frame_wrap) r_frame_count <= r_frame_count + 16'd1;
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = '0;
`endif

  assign hCount     = r_h;
  assign vCount     = r_v;
  assign bright     = r_bright;
  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign pixel_en   = w_pixel_en;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster, against an arithmetic model.
module tb_vga_timing_gen;

  localparam int D     = 4;
  localparam int HT    = 20;
  localparam int HS    = 3;
  localparam int HBP   = 2;
  localparam int HA    = 12;
  localparam int VT    = 10;
  localparam int VS    = 2;
  localparam int VBP   = 2;
  localparam int VA    = 5;
  localparam int FRAME = HT * VT;
`ifdef VGA_FRAME_COUNT_EN
  localparam bit FcEn = 1'b1;
`else
  localparam bit FcEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  hCount, vCount;
  logic        bright, hSync, vSync, pixel_en, frame_tick;
  logic [15:0] frame_count;

  vga_timing_gen #(
    .CLK_DIV (D),
    .H_TOTAL (HT),
    .H_SYNC  (HS),
    .H_BP    (HBP),
    .H_ACTIVE(HA),
    .V_TOTAL (VT),
    .V_SYNC  (VS),
    .V_BP    (VBP),
    .V_ACTIVE(VA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hCount     (hCount),
    .vCount     (vCount),
    .bright     (bright),
    .hSync      (hSync),
    .vSync      (vSync),
    .pixel_en   (pixel_en),
    .frame_tick (frame_tick),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  int n_bright, n_hlow, n_vlow, n_tick, last_tick_k, tick_period, first_pe_k;
  int first_bh, first_bv, last_bh, last_bv;

  function automatic logic [63:0] pack(int h, int v, bit b, bit hs, bit vs, bit pe, bit ft,
                                       int fc);
    logic [9:0]  hh = h[9:0];
    logic [9:0]  vv = v[9:0];
    logic [15:0] ff = fc[15:0];
    return {23'd0, hh, vv, b, hs, vs, pe, ft, ff};
  endfunction

  // k = clock edges since reset released; position index = pixel enables consumed so far.
  function automatic logic [63:0] model(int kk);
    int p, h, v;
    bit pe, ft, br;
    if (kk == 0) return 64'd0;
    p  = (kk - 1) / D;
    h  = p % HT;
    v  = (p / HT) % VT;
    pe = (kk % D) == 0;
    ft = (kk > 1) && ((kk - 1) % D == 0) && (p % FRAME == 0);
    br = (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
    return pack(h, v, br, h >= HS, v >= VS, pe, ft, FcEn ? p / FRAME : 0);
  endfunction

  function automatic logic [63:0] observed();
    return {23'd0, hCount, vCount, bright, hSync, vSync, pixel_en, frame_tick, frame_count};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s k=%0d got %h expected %h", tag, k, obs, exp);
      $error("miscompare in %s", tag);
    end
  endtask

  task automatic clear_stats();
    n_bright = 0; n_hlow = 0; n_vlow = 0; n_tick = 0;
    last_tick_k = -1; tick_period = -1; first_pe_k = -1;
    first_bh = -1; first_bv = -1; last_bh = -1; last_bv = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) k = 0;
    else     k++;
    check("outputs", observed(), model(k));
    if (bright && pixel_en) n_bright++;
    if (!hSync) n_hlow++;
    if (!vSync) n_vlow++;
    if (pixel_en && first_pe_k < 0) first_pe_k = k;
    if (bright) begin
      if (first_bh < 0) begin first_bh = int'(hCount); first_bv = int'(vCount); end
      last_bh = int'(hCount);
      last_bv = int'(vCount);
    end
    if (frame_tick) begin
      n_tick++;
      if (last_tick_k > 0) tick_period = k - last_tick_k;
      last_tick_k = k;
    end
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    check("reset_state", observed(), 64'd0);

    rst = 1'b0;
    clear_stats();
    repeat (D + 1) step();
    check("first_pe_clk", 64'(first_pe_k), 64'(D));
    check("h_after_first_pe", 64'(hCount), 64'd1);
    repeat (3 * FRAME * D - (D + 1)) step();
    check("bright_per_3frames", 64'(n_bright), 64'(3 * HA * VA));
    check("hsync_low_clks", 64'(n_hlow), 64'(3 * VT * HS * D));
    check("vsync_low_clks", 64'(n_vlow), 64'(3 * VS * HT * D));
    check("ticks_in_3frames", 64'(n_tick), 64'd2);
    check("tick_period", 64'(tick_period), 64'(FRAME * D));
    check("first_bright", {32'(first_bh), 32'(first_bv)}, {32'(HS + HBP), 32'(VS + VBP)});
    check("last_bright", {32'(last_bh), 32'(last_bv)},
          {32'(HS + HBP + HA - 1), 32'(VS + VBP + VA - 1)});
    step();
    check("third_tick", 64'(frame_tick), 64'd1);
    check("frame_count_3", 64'(frame_count), FcEn ? 64'd3 : 64'd0);

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(20, 2 * FRAME * D)) step();
      rst = 1'b1;
      step();
      check("mid_reset_state", observed(), 64'd0);
      rst = 1'b0;
      clear_stats();
      repeat (FRAME * D) step();
      check("no_partial_tick", 64'(n_tick), 64'd0);
      step();
      check("tick_after_full_frame", 64'(frame_tick), 64'd1);
      check("frame_count_after_reset", 64'(frame_count), FcEn ? 64'd1 : 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60Hz VGA raster timing: hCount/vCount, active-video flag bright, active-low hSync/vSync. Sits upstream of every pixel/object renderer; those renderers consume hCount, vCount and bright. Also emits a once-per-frame tick, used as the slow update enable for object movement logic, and a pixel enable derived from the system clock.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >=1
H_TOTAL, 800, pixels per line (hCount 0..799)
H_SYNC, 96, hSync low width in pixels (hCount 0..95)
H_BP, 48, horizontal back porch; active starts at H_SYNC+H_BP=144
H_ACTIVE, 640, active pixels; active hCount 144..783
V_TOTAL, 525, lines per frame (vCount 0..524)
V_SYNC, 2, vSync low width in lines (vCount 0..1)
V_BP, 33, vertical back porch; active starts at 35
V_ACTIVE, 480, active lines; active vCount 35..514

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
hCount  out  10  horizontal pixel counter
vCount  out  10  vertical line counter
bright  out  1  1 when (hCount,vCount) is inside the active area
hSync  out  1  horizontal sync, active low
vSync  out  1  vertical sync, active low
pixel_en  out  1  one-clk pulse every CLK_DIV clks; counters advance on it
frame_tick  out  1  one-clk pulse when counters wrap to (0,0)
frame_count  out  16  frames completed since reset (FRAME_COUNT_EN only)

Behaviour:
- One clock (clk). rst is synchronous and active-high, sampled on posedge clk. All outputs are registered.
- Reset values: hCount=0, vCount=0, bright=0, hSync=0, vSync=0 (matches position (0,0), inside both sync pulses), pixel_en=0, frame_tick=0, frame_count=0, divider=0.
- Divider: counts 0..CLK_DIV-1. pixel_en=1 for the clk where the divider wraps, i.e. the first pulse is on the CLK_DIV-th clk after reset release. CLK_DIV=1 -> pixel_en constantly 1 after reset.
- On a pixel_en clk: hCount increments. At H_TOTAL-1, hCount wraps to 0 and vCount increments. vCount at V_TOTAL-1 with hCount wrap -> vCount=0. Counters hold when pixel_en=0.
- hSync/vSync/bright are computed from the next counter values, so they are cycle-aligned with the hCount/vCount registers (zero relative latency):
  hSync=0 iff hCount<H_SYNC; vSync=0 iff vCount<V_SYNC;
  bright=1 iff 144<=hCount<=783 and 35<=vCount<=514 (derived from parameters).
- frame_tick: 1 for exactly one clk, on the clk where the counters register the transition (799,524)->(0,0). It is not asserted at reset.
- Reset mid-frame: the next clk shows all counters/outputs at reset values; the divider restarts, and a partial frame produces no frame_tick.
- Unused width: 10-bit counters never exceed 799/524. Any out-of-range state (e.g. from SEU) wraps to 0 on the next pixel_en.

Optional Feature:
VGA_FRAME_COUNT_EN: when defined, frame_count increments (mod 2^16, 65535->0) on every frame_tick clk. When undefined, the port remains, frame_count is tied to 0, and no counter flops are built.

Decomposition:
- Package vga_timing_pkg: H_*/V_* default constants, derived H_ACT_START=144, H_ACT_END=783, V_ACT_START=35, V_ACT_END=514, and counter width localparam (10).
- Sub-module pixel_en_gen (parameter CLK_DIV; clk, rst in; pixel_en out) holds the divider. The top instantiates it once.

Test Plan:
- Reset release, CLK_DIV=4 -> pixel_en first high on clk 4, then every 4th clk; hCount=1 the clk after the first pixel_en.
- Run one line -> hSync low exactly for hCount 0..95 (96*4=384 clks); hCount 799->0 with vCount 0->1.
- Run a full frame -> vSync low for vCount 0..1; bright high exactly for 640x480=307200 pixel_en clks per frame; first bright at (144,35), last at (783,514).
- Frame wrap -> frame_tick single clk at (799,524)->(0,0); period 800*525*4=1,680,000 clks.
- Assert rst at (400,300) for 1 clk -> next clk all outputs at reset values; no frame_tick until a full frame completes.
- VGA_FRAME_COUNT_EN defined, preload-free run of 3 frames -> frame_count=3; undefined -> frame_count stays 0.
